cache_control: RTL and testbench
================================

// Module: cache_control
// PURPOSE
//  Sequencing FSM for the direct-mapped write-back cache datapath (cache_datapath).
//  Accepts one CPU read/write at a time, checks the hit flag and on a miss writes back
//  the dirty victim, then allocates the line from physical memory and retires the access.
//  Drives the datapath's load enables and writing select; keeps saturating hit/miss/writeback counters.
// PARAMETERS
//  CNT_W  32  width of each performance counter
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      asynchronous, active-high reset
//  mem_read     in   1      CPU read request, held until mem_resp
//  mem_write    in   1      CPU write request, held until mem_resp
//  mem_resp     out  1      one-cycle pulse: CPU access complete
//  pmem_read    out  1      physical memory line read, held until pmem_resp
//  pmem_write   out  1      physical memory line write, held until pmem_resp
//  pmem_resp    in   1      physical memory transfer complete
//  hit          in   1      datapath: valid && tag match at current index
//  dirty_out    in   1      datapath: dirty bit at current index
//  tag_load     out  1      load tag array
//  valid_load   out  1      load valid array (writes 1)
//  dirty_load   out  1      load dirty array with dirty_in
//  dirty_in     out  1      value written to dirty array
//  writing      out  2      00 line fill from pmem, 01 CPU byte-masked write, 10 hold data
//  hit_count    out  CNT_W  completed accesses that hit on first check
//  miss_count   out  CNT_W  accesses that missed on first check
//  wb_count     out  CNT_W  victim write-backs completed
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_resp, pmem_read, pmem_write, tag_load, valid_load,
//   dirty_load, dirty_in = 0; writing = 2'b10; all counters = 0. Outputs are Moore/Mealy
//   decodes of state; default writing=2'b10 in every state/cycle not listed below.
//  States: IDLE, CHECK, WRITEBACK, ALLOCATE, RECHECK.
//  IDLE: mem_read|mem_write -> CHECK (array read of the indexed set settles). Else stay.
//  CHECK: hit -> mem_resp=1, hit_count++, -> IDLE. Write hit additionally: writing=01,
//   dirty_load=1, dirty_in=1 in that cycle. Read hit: no array loads.
//   !hit & dirty_out -> miss_count++, -> WRITEBACK. !hit & !dirty_out -> miss_count++, -> ALLOCATE.
//  WRITEBACK: pmem_write=1 (datapath presents {victim tag, index} while dirty_out=1).
//   On pmem_resp: dirty_load=1, dirty_in=0, wb_count++, -> ALLOCATE. pmem_address then switches to mem_address.
//  ALLOCATE: pmem_read=1. On pmem_resp (same cycle): writing=00, tag_load=1, valid_load=1,
//   dirty_load=1, dirty_in=0, -> RECHECK. writing=00 ONLY in the pmem_resp cycle.
//  RECHECK: behaves as CHECK but never counts a hit/miss; hit is guaranteed; if !hit
//   (protocol error) re-enter miss path without counting.
//  Latency: hit = mem_resp 2 cycles after request first seen in IDLE (IDLE, CHECK);
//   clean miss = 3 + pmem latency; dirty miss adds one full pmem write transaction.
//  mem_read & mem_write both high: treated as write. Request dropped mid-miss: fill/writeback
//   still completes, then RECHECK with no request -> IDLE, no mem_resp, no counter change.
//  pmem_resp in IDLE/CHECK/RECHECK: ignored. pmem_read and pmem_write never both 1.
//  Counters saturate at all-ones (no wrap). Reset mid-transaction: immediate IDLE, pmem
//   strobes drop asynchronously; memory must tolerate an abandoned transfer.
// TESTING
//  Reset, read addr 0x0000_0040 to empty cache -> pmem_read with addr 0x40, after pmem_resp
//   mem_resp one cycle after RECHECK; miss_count=1, hit_count=0, wb_count=0.
//  Repeat read 0x40 -> mem_resp exactly 2 cycles after request, no pmem activity, hit_count=1.
//  Write 0x40 byte_enable 0x0000_000F -> writing=01, dirty_load=1, dirty_in=1 in CHECK, mem_resp same cycle.
//  Read 0x0000_0240 (same index, new tag) -> pmem_write at 0x40 first, then pmem_read at 0x240;
//   wb_count=1, miss_count=2; written bytes visible in pmem_wdata.
//  Hold pmem_resp low 20 cycles in ALLOCATE -> pmem_read stays 1, writing stays 10, no loads.
//  Assert rst during WRITEBACK -> pmem_write=0 before next edge, state IDLE, counters 0;
//   preload counters near 2^CNT_W-1 (CNT_W=4) -> hit_count holds at 15.

Source files
------------

// File: rtl/cache_control.sv
// Sequencing FSM for the direct-mapped write-back cache: hit check, victim write-back,
// line allocation and recheck, plus saturating hit/miss/write-back counters.
module cache_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             hit,
  input  logic             dirty_out,
  output logic             tag_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             dirty_in,
  output logic [1:0]       writing,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    RECHECK   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_reg, state_next;
  logic   hit_inc, miss_inc, wb_inc;
  logic   req;

  // A simultaneous read and write is serviced as a write.
  assign req = mem_read | mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    tag_load   = 1'b0;
    valid_load = 1'b0;
    dirty_load = 1'b0;
    dirty_in   = 1'b0;
    writing    = 2'b10;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    wb_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) state_next = CHECK;
      end
      CHECK, RECHECK: begin
        // An abandoned request is only possible after a miss; drop it quietly.
        if (state_reg == RECHECK && !req) begin
          state_next = IDLE;
        end else if (hit) begin
          mem_resp   = 1'b1;
          hit_inc    = (state_reg == CHECK);
          state_next = IDLE;
          if (mem_write) begin
            writing    = 2'b01;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end else begin
          miss_inc   = (state_reg == CHECK);
          state_next = dirty_out ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          dirty_load = 1'b1;
          wb_inc     = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          writing    = 2'b00;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          state_next = RECHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_inc && hit_count != CNT_MAX)   hit_count  <= hit_count + 1'b1;
      if (miss_inc && miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
      if (wb_inc && wb_count != CNT_MAX)     wb_count   <= wb_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: cycle-by-cycle vector table plus hand sequences
// for a long allocate stall, reset during write-back and counter saturation.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, pmem_resp, hit, dirty_out;
  logic        mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in;
  logic [1:0]  writing;
  logic [31:0] hit_count, miss_count, wb_count;

  logic        s_rst, s_mem_read, s_mem_write, s_pmem_resp, s_hit, s_dirty_out;
  logic        s_mem_resp, s_pmem_read, s_pmem_write, s_tag_load, s_valid_load;
  logic        s_dirty_load, s_dirty_in;
  logic [1:0]  s_writing;
  logic [3:0]  s_hit_count, s_miss_count, s_wb_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit(hit), .dirty_out(dirty_out),
    .tag_load(tag_load), .valid_load(valid_load), .dirty_load(dirty_load),
    .dirty_in(dirty_in), .writing(writing), .hit_count(hit_count),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_control #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(s_rst), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_resp(s_pmem_resp), .hit(s_hit), .dirty_out(s_dirty_out),
    .tag_load(s_tag_load), .valid_load(s_valid_load), .dirty_load(s_dirty_load),
    .dirty_in(s_dirty_in), .writing(s_writing), .hit_count(s_hit_count),
    .miss_count(s_miss_count), .wb_count(s_wb_count)
  );

  // Expected control word: {mem_resp, pmem_read, pmem_write, tag_load, valid_load,
  //                         dirty_load, dirty_in, writing[1:0]}
  localparam logic [8:0] O_IDLE  = 9'b0_0_0_0_0_0_0_10;
  localparam logic [8:0] O_AWAIT = 9'b0_1_0_0_0_0_0_10;
  localparam logic [8:0] O_AFILL = 9'b0_1_0_1_1_1_0_00;
  localparam logic [8:0] O_RDHIT = 9'b1_0_0_0_0_0_0_10;
  localparam logic [8:0] O_WRHIT = 9'b1_0_0_0_0_1_1_01;
  localparam logic [8:0] O_WWAIT = 9'b0_0_1_0_0_0_0_10;
  localparam logic [8:0] O_WDONE = 9'b0_0_1_0_0_1_0_10;

  typedef struct {
    logic       rd, wr, h, d, pr;
    logic [8:0] exp;
    int         eh, em, ew;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, wr, h, d, pr, input logic [8:0] exp,
                     input int eh, em, ew);
    vec_t v;
    v.rd = rd; v.wr = wr; v.h = h; v.d = d; v.pr = pr;
    v.exp = exp; v.eh = eh; v.em = em; v.ew = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {mem_resp, pmem_read, pmem_write, tag_load, valid_load,
            dirty_load, dirty_in, writing};
  endfunction

  task automatic drive(input logic rd, wr, h, d, pr);
    mem_read = rd; mem_write = wr; hit = h; dirty_out = d; pmem_resp = pr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; drive(0, 0, 0, 0, 0);
    s_rst = 1'b1; s_mem_read = 0; s_mem_write = 0; s_pmem_resp = 0; s_hit = 0; s_dirty_out = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctl", {23'd0, ctl()}, {23'd0, O_IDLE});
    check("reset_hit_count", hit_count, 0);
    check("reset_miss_count", miss_count, 0);
    rst = 1'b0; s_rst = 1'b0;

    //   rd wr h  d  pr  expected  hit miss wb
    add(0, 0, 0, 0, 0, O_IDLE,  0, 0, 0); // idle
    add(1, 0, 0, 0, 0, O_IDLE,  0, 0, 0); // read 0x40 seen
    add(1, 0, 0, 0, 0, O_IDLE,  0, 0, 0); // CHECK clean miss
    add(1, 0, 0, 0, 0, O_AWAIT, 0, 1, 0); // ALLOCATE waiting
    add(1, 0, 0, 0, 1, O_AFILL, 0, 1, 0); // ALLOCATE fill
    add(1, 0, 1, 0, 0, O_RDHIT, 0, 1, 0); // RECHECK hit
    add(1, 0, 0, 0, 0, O_IDLE,  0, 1, 0); // repeat read
    add(1, 0, 1, 0, 0, O_RDHIT, 0, 1, 0); // CHECK read hit
    add(0, 1, 0, 0, 0, O_IDLE,  1, 1, 0); // write 0x40
    add(0, 1, 1, 0, 0, O_WRHIT, 1, 1, 0); // CHECK write hit
    add(1, 0, 0, 1, 0, O_IDLE,  2, 1, 0); // read 0x240
    add(1, 0, 0, 1, 0, O_IDLE,  2, 1, 0); // CHECK dirty miss
    add(1, 0, 0, 1, 0, O_WWAIT, 2, 2, 0); // WRITEBACK waiting
    add(1, 0, 0, 1, 1, O_WDONE, 2, 2, 0); // WRITEBACK done
    add(1, 0, 0, 0, 0, O_AWAIT, 2, 2, 1); // ALLOCATE waiting
    add(1, 0, 0, 0, 1, O_AFILL, 2, 2, 1); // ALLOCATE fill
    add(1, 0, 1, 0, 0, O_RDHIT, 2, 2, 1); // RECHECK hit
    add(1, 1, 0, 0, 0, O_IDLE,  2, 2, 1); // read+write together
    add(1, 1, 1, 0, 0, O_WRHIT, 2, 2, 1); // treated as write hit
    add(0, 1, 0, 0, 0, O_IDLE,  3, 2, 1); // write, to be dropped
    add(0, 1, 0, 0, 0, O_IDLE,  3, 2, 1); // CHECK clean miss
    add(0, 0, 0, 0, 1, O_AFILL, 3, 3, 1); // request dropped, fill completes
    add(0, 0, 1, 0, 0, O_IDLE,  3, 3, 1); // RECHECK with no request
    add(0, 0, 0, 0, 1, O_IDLE,  3, 3, 1); // stray pmem_resp in IDLE
    add(1, 0, 0, 0, 0, O_IDLE,  3, 3, 1); // read
    add(1, 0, 1, 0, 1, O_RDHIT, 3, 3, 1); // CHECK hit, stray pmem_resp
    add(0, 0, 0, 0, 0, O_IDLE,  4, 3, 1); // idle
    add(1, 0, 0, 0, 0, O_IDLE,  4, 3, 1); // read
    add(1, 0, 0, 0, 0, O_IDLE,  4, 3, 1); // CHECK clean miss
    add(1, 0, 0, 0, 1, O_AFILL, 4, 4, 1); // fill
    add(1, 0, 0, 0, 0, O_IDLE,  4, 4, 1); // RECHECK misses: protocol error
    add(1, 0, 0, 0, 0, O_AWAIT, 4, 4, 1); // back in ALLOCATE, uncounted
    add(1, 0, 0, 0, 1, O_AFILL, 4, 4, 1); // fill again
    add(1, 0, 1, 0, 0, O_RDHIT, 4, 4, 1); // RECHECK hit
    add(0, 0, 0, 0, 0, O_IDLE,  4, 4, 1); // idle

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].h, vecs[i].d, vecs[i].pr);
      #1;
      checks++;
      if (ctl() !== vecs[i].exp || hit_count !== 32'(vecs[i].eh) ||
          miss_count !== 32'(vecs[i].em) || wb_count !== 32'(vecs[i].ew)) begin
        failures++;
        $display("FAIL vec%0d actual ctl=%b h/m/w=%0d/%0d/%0d required ctl=%b h/m/w=%0d/%0d/%0d",
                 i, ctl(), hit_count, miss_count, wb_count,
                 vecs[i].exp, vecs[i].eh, vecs[i].em, vecs[i].ew);
      end
      $display("vec%0d rd=%0b wr=%0b hit=%0b dirty=%0b presp=%0b ctl=%b", i,
               vecs[i].rd, vecs[i].wr, vecs[i].h, vecs[i].d, vecs[i].pr, ctl());
      step();
    end

    // Long pmem stall in ALLOCATE: strobe held, no loads, data held.
    drive(1, 0, 0, 0, 0); step(); step();
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("stall_ctl%0d", c), {23'd0, ctl()}, {23'd0, O_AWAIT});
      step();
    end
    drive(1, 0, 0, 0, 1); #1;
    check("stall_fill", {23'd0, ctl()}, {23'd0, O_AFILL});
    step();
    drive(1, 0, 1, 0, 0); #1;
    check("stall_resp", {23'd0, ctl()}, {23'd0, O_RDHIT});
    check("stall_miss_count", miss_count, 5);
    step();
    drive(0, 0, 0, 0, 0);
    $display("stall sequence done miss_count=%0d", miss_count);

    // Reset while a write-back is in flight.
    drive(1, 0, 0, 1, 0); step(); step();
    #1;
    check("wb_pre_reset", {31'd0, pmem_write}, 1);
    #1 rst = 1'b1;
    #1;
    check("wb_reset_strobe", {31'd0, pmem_write}, 0);
    check("wb_reset_ctl", {23'd0, ctl()}, {23'd0, O_IDLE});
    check("wb_reset_miss_count", miss_count, 0);
    check("wb_reset_hit_count", hit_count, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    #1;
    check("post_reset_idle", {23'd0, ctl()}, {23'd0, O_IDLE});
    $display("reset-during-writeback sequence done");

    // Saturation on the 4-bit instance: 17 read hits.
    s_mem_read = 1'b1; s_hit = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step(); // IDLE -> CHECK
      #1;
      check($sformatf("sat_resp%0d", k), {31'd0, s_mem_resp}, 1);
      step(); // CHECK -> IDLE
      if (k == 14) check("sat_at_15", {28'd0, s_hit_count}, 15);
    end
    #1;
    check("sat_hold_15", {28'd0, s_hit_count}, 15);
    check("sat_miss_zero", {28'd0, s_miss_count}, 0);
    s_mem_read = 1'b0; s_hit = 1'b0;
    $display("saturation sequence done hit_count=%0d", s_hit_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
